// File: rtl/header_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : header_parser_pkg
// Brief   : IOQ module-header defines and the parsed header vector type.
// Revision: 1.0 - initial release
// ============================================================================
package header_parser_pkg;

    // IOQ module header identification and field placement
    localparam logic [7:0] c_IOQ_HDR_CTRL     = 8'hFF;
    localparam int         c_IOQ_SRC_PORT_POS = 16;
    localparam int         c_IOQ_BYTE_LEN_POS = 0;
    localparam int         c_IOQ_FIELD_W      = 16;

    // Byte lane (from LSB) carrying the low byte of the ethertype in E2
    localparam int         c_ETYPE_LO_LANE    = 2;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] byte_len;
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic        short_pkt;
    } hdr_vec_t;

endpackage
`default_nettype wire

// File: rtl/small_fifo.sv
`default_nettype none
// ============================================================================
// Module  : small_fifo
// Brief   : Synchronous FIFO with combinational read port and nearly-full flag.
// Revision: 1.0 - initial release
// ============================================================================
module small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_nearly_full,
    output logic             o_empty
);

    localparam int                      c_DEPTH    = 2 ** MAX_DEPTH_BITS;
    localparam int                      c_NF_INT   = c_DEPTH - 2;
    localparam logic [MAX_DEPTH_BITS:0] c_FULL_CNT = c_DEPTH[MAX_DEPTH_BITS:0];
    // Two-entry margin: a writer reacting one cycle late still fits
    localparam logic [MAX_DEPTH_BITS:0] c_NF_CNT   = c_NF_INT[MAX_DEPTH_BITS:0];

    logic [WIDTH-1:0]          r_mem [c_DEPTH];
    logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
    logic [MAX_DEPTH_BITS:0]   r_count;
    logic                      w_full;
    logic                      w_wr;
    logic                      w_rd;

    assign w_full        = (r_count == c_FULL_CNT);
    assign o_empty       = (r_count == '0);
    assign o_nearly_full = (r_count >= c_NF_CNT);
    assign w_wr          = i_wr_en & ~w_full;
    assign w_rd          = i_rd_en & ~o_empty;
    assign o_dout        = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/header_parser.sv
`default_nettype none
// ============================================================================
// Module  : header_parser
// Brief   : Extracts IOQ/Ethernet header fields while buffering the packet.
// Revision: 1.0 - initial release
// ============================================================================
module header_parser
    import header_parser_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH_BITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  hdr_vld,
    input  logic                  hdr_rdy,
    output logic [15:0]           hdr_src_port,
    output logic [15:0]           hdr_byte_len,
    output logic [47:0]           hdr_dst_mac,
    output logic [47:0]           hdr_src_mac,
    output logic [15:0]           hdr_ethertype,
    output logic                  hdr_short
);

    localparam logic [1:0] c_MOD_HDRS = 2'd0;
    localparam logic [1:0] c_ETH_W1   = 2'd1;
    localparam logic [1:0] c_ETH_W2   = 2'd2;
    localparam logic [1:0] c_WAIT_EOP = 2'd3;

    localparam int c_FIFO_W = DATA_WIDTH + CTRL_WIDTH;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    hdr_vec_t            r_cap;
    hdr_vec_t            w_cap_nxt;
    hdr_vec_t            r_slot;
    logic                r_slot_full;
    logic                r_cap_done;
    logic                w_done;
    logic                w_pop;
    logic                w_ctrl_zero;
    logic                w_is_ioq;
    logic                w_trunc;
    logic                w_fifo_nf;
    logic                w_fifo_empty;
    logic                w_fifo_rd;
    logic [c_FIFO_W-1:0] w_fifo_dout;

    assign w_ctrl_zero = (in_ctrl == '0);
    assign w_is_ioq    = (in_ctrl == CTRL_WIDTH'(c_IOQ_HDR_CTRL));
    // An EOP whose last valid byte lies above the ethertype cuts it off
    assign w_trunc     = |(in_ctrl >> (c_ETYPE_LO_LANE + 1));
    assign w_pop       = r_slot_full & hdr_rdy;

    assign in_rdy = ~reset & ~w_fifo_nf &
                    ~(r_slot_full & r_cap_done & (r_state == c_MOD_HDRS));

    always_comb begin
        w_state_nxt = r_state;
        w_cap_nxt   = r_cap;
        w_done      = 1'b0;
        if (in_wr) begin
            case (r_state)
                c_MOD_HDRS, c_ETH_W1: begin
                    if (r_state == c_MOD_HDRS) begin
                        w_cap_nxt = '0;
                    end
                    if (w_ctrl_zero) begin
                        w_cap_nxt.dst_mac        = in_data[63:16];
                        w_cap_nxt.src_mac[47:32] = in_data[15:0];
                        w_state_nxt              = c_ETH_W2;
                    end else begin
                        if (w_is_ioq) begin
                            w_cap_nxt.src_port = in_data[c_IOQ_SRC_PORT_POS +: c_IOQ_FIELD_W];
                            w_cap_nxt.byte_len = in_data[c_IOQ_BYTE_LEN_POS +: c_IOQ_FIELD_W];
                        end
                        w_state_nxt = c_ETH_W1;
                    end
                end
                c_ETH_W2: begin
                    w_done = 1'b1;
                    if (!w_ctrl_zero && w_trunc) begin
                        w_cap_nxt.short_pkt     = 1'b1;
                        w_cap_nxt.ethertype     = '0;
                        w_cap_nxt.src_mac[31:0] = '0;
                        w_state_nxt             = c_MOD_HDRS;
                    end else begin
                        w_cap_nxt.short_pkt     = 1'b0;
                        w_cap_nxt.src_mac[31:0] = in_data[63:32];
                        w_cap_nxt.ethertype     = in_data[31:16];
                        w_state_nxt             = w_ctrl_zero ? c_WAIT_EOP : c_MOD_HDRS;
                    end
                end
                c_WAIT_EOP: begin
                    if (!w_ctrl_zero) begin
                        w_state_nxt = c_MOD_HDRS;
                    end
                end
                default: w_state_nxt = c_MOD_HDRS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_MOD_HDRS;
            r_cap       <= '0;
            r_slot      <= '0;
            r_slot_full <= 1'b0;
            r_cap_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cap   <= w_cap_nxt;
            if (!r_slot_full || w_pop) begin
                // Slot is free this cycle: oldest completed vector goes first
                if (r_cap_done) begin
                    r_slot      <= r_cap;
                    r_slot_full <= 1'b1;
                    r_cap_done  <= w_done;
                end else if (w_done) begin
                    r_slot      <= w_cap_nxt;
                    r_slot_full <= 1'b1;
                end else begin
                    r_slot_full <= 1'b0;
                end
            end else if (w_done) begin
                r_cap_done <= 1'b1;
            end
        end
    end

    assign hdr_vld       = r_slot_full;
    assign hdr_src_port  = r_slot.src_port;
    assign hdr_byte_len  = r_slot.byte_len;
    assign hdr_dst_mac   = r_slot.dst_mac;
    assign hdr_src_mac   = r_slot.src_mac;
    assign hdr_ethertype = r_slot.ethertype;
    assign hdr_short     = r_slot.short_pkt;

    assign w_fifo_rd = ~w_fifo_empty & out_rdy;

    small_fifo #(
        .WIDTH          (c_FIFO_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_pkt_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_din         ({in_ctrl, in_data}),
        .i_wr_en       (in_wr),
        .i_rd_en       (w_fifo_rd),
        .o_dout        (w_fifo_dout),
        .o_nearly_full (w_fifo_nf),
        .o_empty       (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            out_wr <= w_fifo_rd;
            if (w_fifo_rd) begin
                out_data <= w_fifo_dout[DATA_WIDTH-1:0];
                out_ctrl <= w_fifo_dout[DATA_WIDTH +: CTRL_WIDTH];
            end
        end
    end

endmodule
`default_nettype wire
